// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   arb_state_e : arbiter state encoding (ST_IDLE, ST_GRANT, ST_PARK)
//   onehot()    : index -> one-hot vector, MAX_INPUT bits wide; callers cast it down to their width
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_PARK  = 2'd2
    } arb_state_e;

    localparam int unsigned MAX_INPUT = 32;

    function automatic logic [MAX_INPUT-1:0] onehot(input int unsigned idx);
        onehot = MAX_INPUT'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the first set request bit searching upward from
// (last + 1) mod NUM_INPUT, wrapping.
//   req     : request vector, bit i = source i
//   last    : index of the previous winner
//   winner  : chosen index; equals last when nothing is requested
//   any_req : at least one request bit set
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_INPUT = 8,
    parameter int unsigned SEL_BIT   = 3
) (
    input  logic [NUM_INPUT-1:0] req,
    input  logic [SEL_BIT-1:0]   last,
    output logic [SEL_BIT-1:0]   winner,
    output logic                 any_req
);

    always_comb begin
        int unsigned idx;
        winner  = last;
        any_req = |req;
        // Walk from the farthest candidate to the nearest; the last hit is the nearest.
        for (int unsigned i = NUM_INPUT; i > 0; i--) begin
            idx = (32'(last) + i) % NUM_INPUT;
            if (|(req & (NUM_INPUT'(1) << idx))) begin
                winner = SEL_BIT'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter driving the select lines of the shared tristate data bus.
// Grants one source at a time, holds the grant while the owner keeps requesting,
// and inserts one PARK cycle between owners so two drivers never overlap.
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   req_in        : per-source level requests
//   grant_out     : registered one-hot grant, zero when no owner
//   sel_out       : registered index of current/last owner (mux select)
//   bus_valid_out : high while an owner holds the bus
//   timeout_out   : one-cycle pulse when a grant is revoked for holding too long
// Optional: define BUS_ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_INPUT = 8,
    parameter int unsigned SEL_BIT   = 3,
    parameter int unsigned MAX_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_INPUT-1:0] req_in,
    output logic [NUM_INPUT-1:0] grant_out,
    output logic [SEL_BIT-1:0]   sel_out,
    output logic                 bus_valid_out,
    output logic                 timeout_out
);

    if (NUM_INPUT > (1 << SEL_BIT)) begin : g_bad_sel
        $error("NUM_INPUT does not fit in SEL_BIT select bits");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("MAX_HOLD must be at least 2");
    end

    localparam logic [SEL_BIT-1:0] LAST_RST = SEL_BIT'(NUM_INPUT - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_INPUT-1:0]   grant_q, grant_d;
    logic [SEL_BIT-1:0]     sel_q, sel_d;
    logic [SEL_BIT-1:0]     last_q, last_d;
    logic                   valid_q, valid_d;
    logic [SEL_BIT-1:0]     winner;
    logic                   any_req;
    logic                   owner_req;

    rr_priority_pick #(
        .NUM_INPUT (NUM_INPUT),
        .SEL_BIT   (SEL_BIT)
    ) u_pick (
        .req     (req_in),
        .last    (last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // Grant is one-hot, so masking avoids indexing req_in with sel.
    assign owner_req = |(req_in & grant_q);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned    HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    // hold_q is 0 in the first visible grant cycle, so HOLD_LAST marks MAX_HOLD cycles held.
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = timeout_q;
`else
    assign timeout_out = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        valid_d = valid_q;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef BUS_ARB_TIMEOUT_EN
                hold_d = '0;
`endif
                if (any_req) begin
                    state_d = ST_GRANT;
                    grant_d = NUM_INPUT'(onehot(32'(winner)));
                    sel_d   = winner;
                    last_d  = winner;
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    state_d = ST_PARK;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    state_d   = ST_PARK;
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            ST_PARK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= LAST_RST;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign grant_out     = grant_q;
    assign sel_out       = sel_q;
    assign bus_valid_out = valid_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus randomized requests,
// compared every cycle against a behavioural owner/pointer model.
module tb_bus_arbiter_rr;

    localparam int unsigned N  = 8;
    localparam int unsigned SB = 3;
    localparam int unsigned MH = 16;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [SB-1:0] sel;
    logic          valid;
    logic          timeout;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_INPUT (N),
        .SEL_BIT   (SB),
        .MAX_HOLD  (MH)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req),
        .grant_out     (grant),
        .sel_out       (sel),
        .bus_valid_out (valid),
        .timeout_out   (timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, whether a turnaround is pending,
    // the round-robin pointer, and how long the owner has held.
    int m_owner;
    int m_last;
    int m_sel;
    int m_held;
    bit m_park;
    bit m_to;

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_sel   = 0;
        m_held  = 0;
        m_park  = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int c;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_park  = 1'b1;
            end else if (TO_EN && m_held == MH) begin
                m_owner = -1;
                m_park  = 1'b1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_park) begin
            m_park = 1'b0;
        end else if (r != 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (r[c]) begin
                    m_owner = c;
                    break;
                end
            end
            m_sel  = m_owner;
            m_last = m_owner;
            m_held = 1;
        end
    endtask

    task automatic compare_outputs();
        check_eq("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check_eq("sel", 32'(sel), 32'(m_sel));
        check_eq("valid", 32'(valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        check_eq("timeout", 32'(timeout), 32'(m_to));
        check_eq("onehot0", 32'($onehot0(grant)), 32'd1);
        check_eq("valid_vs_grant", 32'(valid), 32'(grant != '0));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(req);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        compare_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        bit  pv;
        int  gap;
        int  cnt;
        int  pulses;
        int  order[$];
        int  gaps[$];
        logic [N-1:0] mask;

        rst_n = 1'b0;
        req   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_outputs();
        rst_n = 1'b1;

        // Idle after reset.
        repeat (5) step();

        // Two requesters: 0 then 2 after the turnaround.
        req = 8'h05;
        step();
        check_eq("t2_first_sel", 32'(sel), 32'd0);
        repeat (3) step();
        req = 8'h04;
        step();
        check_eq("t2_park_valid", 32'(valid), 32'd0);
        step();
        check_eq("t2_idle_valid", 32'(valid), 32'd0);
        step();
        check_eq("t2_second_sel", 32'(sel), 32'd2);
        check_eq("t2_second_grant", 32'(grant), 32'h04);
        req = '0;
        repeat (3) step();

        // All eight requesting, each owner releasing after 3 grant cycles.
        do_reset();
        req = '1;
        gap = 0;
        for (int s = 0; s < 44; s++) begin
            pv = valid;
            step();
            if (valid && !pv) begin
                order.push_back(int'(sel));
                gaps.push_back(gap);
                gap = 0;
            end else if (!valid) begin
                gap++;
            end
            req = '1;
            if (m_owner >= 0 && m_held == 3) req[m_owner] = 1'b0;
        end
        check_eq("t3_num_grants", 32'(order.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < order.size()) begin
                check_eq($sformatf("t3_order%0d", i), 32'(order[i]), 32'(i % N));
                if (i > 0) check_eq($sformatf("t3_gap%0d", i), 32'(gaps[i]), 32'd2);
            end
        end
        req = '0;
        repeat (3) step();

        // Lone requester 7, toggling: the search wraps from the pointer.
        do_reset();
        for (int t = 0; t < 3; t++) begin
            req = 8'h80;
            step();
            check_eq("t4_sel7", 32'(sel), 32'd7);
            step();
            req = '0;
            step();
            req = 8'h80;
            step();
            check_eq("t4_regrant_gap", 32'(valid), 32'd0);
            step();
            check_eq("t4_regrant", 32'(grant), 32'h80);
            req = '0;
            repeat (2) step();
        end

        // Asynchronous reset in the middle of source 4's grant.
        do_reset();
        req = 8'h10;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_grant", 32'(grant), 32'd0);
        check_eq("t5_async_valid", 32'(valid), 32'd0);
        check_eq("t5_async_sel", 32'(sel), 32'd0);
        check_eq("t5_async_timeout", 32'(timeout), 32'd0);
        model_reset();
        @(negedge clk);
        req   = 8'h11;
        rst_n = 1'b1;
        step();
        check_eq("t5_src0_wins", 32'(grant), 32'h01);
        req = '0;
        repeat (3) step();

        // Long hold by source 3 with source 5 waiting.
        do_reset();
        req    = 8'h28;
        cnt    = 0;
        pulses = 0;
        for (int s = 0; s < 30; s++) begin
            step();
            if (grant == 8'h08) cnt++;
            if (timeout) pulses++;
        end
        check_eq("t6_hold_cycles", 32'(cnt), TO_EN ? 32'd16 : 32'd30);
        check_eq("t6_pulses", 32'(pulses), TO_EN ? 32'd1 : 32'd0);
        check_eq("t6_final_sel", 32'(sel), TO_EN ? 32'd5 : 32'd3);
        req = '0;
        repeat (4) step();

        // Randomized requests: each bit flips with probability 1/8 per cycle.
        do_reset();
        for (int s = 0; s < 2000; s++) begin
            mask = '0;
            for (int b = 0; b < N; b++) mask[b] = ($urandom_range(7) == 0);
            req = req ^ mask;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
